// File: rtl/text_buffer_uart_dump.sv
// text_buffer_uart_dump
//   Streams the whole text buffer out of a UART, row-major, one 8N1 frame
//   per cell with CR/LF after every row. Non-printable codes become spaces.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high
//   dump_start single-cycle request, ignored while a dump is running
//   rd_x/rd_y  text buffer read address (column/row)
//   rd_char    buffer data, valid one cycle after the address
//   tx         UART serial output, idle high
//   busy       high while a dump is in progress
//   done       one-cycle pulse after the final stop bit
//
// CLKS_PER_BIT must be at least 3.
module text_buffer_uart_dump #(
  parameter int CLKS_PER_BIT = 868,
  parameter int COLS         = 80,
  parameter int ROWS         = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dump_start,
  output logic [6:0] rd_x,
  output logic [4:0] rd_y,
  input  logic [7:0] rd_char,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [6:0] X_LAST = 7'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, CAPTURE, START, DATA, STOP, CR, LF, FIN
  } state_t;

  typedef enum logic [1:0] {K_CELL, K_CR, K_LF} kind_t;

  state_t           r_state, w_next;
  kind_t            r_kind;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_stop_last;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       w_filt;
  logic [6:0]       r_x;
  logic [4:0]       r_y;
  logic             w_bit_end;
  logic             w_stop_end;
  logic             w_x_last;
  logic             w_y_last;

  assign rd_x      = r_x;
  assign rd_y      = r_y;
  assign w_x_last  = (r_x == X_LAST);
  assign w_y_last  = (r_y == Y_LAST);
  assign w_bit_end = (r_cnt == BIT_LAST);
  assign w_filt    = (rd_char < 8'h20 || rd_char > 8'h7E) ? 8'h20 : rd_char;

  // The STOP state is cut short by the number of tx-high cycles spent in the
  // states that follow (ADDR+CAPTURE = 2, CR or LF = 1, FIN = 0), so the line
  // sees exactly CLKS_PER_BIT high cycles and frames run back to back.
  always_comb begin
    w_stop_last = BIT_LAST;
    case (r_kind)
      K_CELL:  w_stop_last = w_x_last ? BIT_LAST - CNT_W'(1) : BIT_LAST - CNT_W'(2);
      K_CR:    w_stop_last = BIT_LAST - CNT_W'(1);
      K_LF:    w_stop_last = w_y_last ? BIT_LAST : BIT_LAST - CNT_W'(2);
      default: w_stop_last = BIT_LAST;
    endcase
  end

  assign w_stop_end = (r_cnt == w_stop_last);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    tx     = 1'b1;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (dump_start) w_next = ADDR;
      end
      ADDR:    w_next = CAPTURE;
      CAPTURE: w_next = START;
      START: begin
        tx = 1'b0;
        if (w_bit_end) w_next = DATA;
      end
      DATA: begin
        tx = r_shift[0];
        if (w_bit_end && r_bit == 3'd7) w_next = STOP;
      end
      STOP: begin
        if (w_stop_end) begin
          case (r_kind)
            K_CELL:  w_next = w_x_last ? CR : ADDR;
            K_CR:    w_next = LF;
            K_LF:    w_next = w_y_last ? FIN : ADDR;
            default: w_next = IDLE;
          endcase
        end
      end
      CR:  w_next = START;
      LF:  w_next = START;
      FIN: begin
        busy   = 1'b0;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_kind  <= K_CELL;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        IDLE: begin
          if (dump_start) begin
            r_x <= '0;
            r_y <= '0;
          end
        end
        CAPTURE: begin
          r_shift <= w_filt;
          r_kind  <= K_CELL;
        end
        CR: begin
          r_shift <= 8'h0D;
          r_kind  <= K_CR;
        end
        LF: begin
          r_shift <= 8'h0A;
          r_kind  <= K_LF;
        end
        START: begin
          r_bit <= '0;
          if (!w_bit_end) r_cnt <= r_cnt + CNT_W'(1);
        end
        DATA: begin
          if (w_bit_end) begin
            r_bit   <= r_bit + 3'd1;
            r_shift <= {1'b0, r_shift[7:1]};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (w_stop_end) begin
            case (r_kind)
              K_CELL: begin
                if (!w_x_last) r_x <= r_x + 7'd1;
              end
              K_LF: begin
                r_x <= '0;
                if (!w_y_last) r_y <= r_y + 5'd1;
              end
              default: ;
            endcase
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer_uart_dump.sv
module tb_text_buffer_uart_dump;

  localparam int CPB   = 4;
  localparam int COLS  = 2;
  localparam int ROWS  = 2;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       dump_start;
  logic [6:0] rd_x;
  logic [4:0] rd_y;
  logic [7:0] rd_char;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] mem [0:3];
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  b;
    int unsigned c;
  } frame_t;

  frame_t      fq[$];
  int unsigned dq[$];

  text_buffer_uart_dump #(
    .CLKS_PER_BIT(CPB),
    .COLS(COLS),
    .ROWS(ROWS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dump_start(dump_start),
    .rd_x(rd_x),
    .rd_y(rd_y),
    .rd_char(rd_char),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer with one cycle of read latency.
  always @(posedge clk) begin
    if (int'(rd_x) < COLS && int'(rd_y) < ROWS)
      rd_char <= mem[int'(rd_y) * COLS + int'(rd_x)];
    else
      rd_char <= 8'hFF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] wave(input logic [7:0] b);
    logic [39:0] w;
    for (int k = 0; k < 40; k++) begin
      int j;
      j = k / 4;
      w[k] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
    end
    return w;
  endfunction

  // Frame monitor: captures 40 consecutive samples from a start bit and
  // compares the whole waveform and its start cycle against the queue head.
  logic [39:0] m_s;
  int unsigned m_c;
  bit          m_abort;
  frame_t      m_e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        m_c     = cyc;
        m_abort = 1'b0;
        m_s[0]  = tx;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (reset !== 1'b0) m_abort = 1'b1;
          m_s[k] = tx;
        end
        if (!m_abort) begin
          if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%0h expected=none (start cycle %0d)", m_s, m_c);
          end else begin
            m_e = fq.pop_front();
            chk("frame_bits", m_s, wave(m_e.b));
            chk("frame_start_cycle", m_c, m_e.c);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        chk("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic pulse_start(output int unsigned c0);
    @(posedge clk); #1;
    dump_start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    dump_start = 1'b0;
  endtask

  // e holds up to 8 bytes, first frame in the top byte.
  task automatic expect_frames(input int unsigned c0, input logic [63:0] e, input int n);
    for (int k = 0; k < n; k++)
      fq.push_back('{e[63-8*k -: 8], c0 + 3 + k * FRAME});
  endtask

  // Follows a full dump; with rep set, dump_start is re-pulsed inside the
  // second frame and again on the FIN cycle.
  task automatic wait_dump(input int unsigned c0, input bit rep);
    int unsigned tdone;
    int bad;
    tdone = c0 + 3 + 8 * FRAME;
    bad   = 0;
    forever begin
      @(negedge clk);
      if (cyc >= tdone) break;
      if (busy !== 1'b1) bad++;
      @(posedge clk); #1;
      dump_start = rep && (cyc == c0 + 3 + FRAME + 10 || cyc == tdone);
    end
    chk("busy_during_dump", bad, 0);
    chk("busy_in_fin", busy, 0);
    @(posedge clk); #1;
    dump_start = 1'b0;
    repeat (rep ? 60 : 3) @(negedge clk);
    chk("frames_left", fq.size(), 0);
    chk("busy_after_dump", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned c0;
    reset      = 1'b1;
    dump_start = 1'b0;
    load(8'h20, 8'h20, 8'h20, 8'h20);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_x", rd_x, 0);
    chk("reset_rd_y", rd_y, 0);

    // "AB" / "CD"
    load(8'h41, 8'h42, 8'h43, 8'h44);
    pulse_start(c0);
    expect_frames(c0, 64'h41420D0A43440D0A, 8);
    dq.push_back(c0 + 3 + 8 * FRAME);
    wait_dump(c0, 1'b0);

    // Non-printable codes on both sides of the printable range
    load(8'h07, 8'h80, 8'h1F, 8'h7F);
    pulse_start(c0);
    expect_frames(c0, 64'h20200D0A20200D0A, 8);
    dq.push_back(c0 + 3 + 8 * FRAME);
    wait_dump(c0, 1'b0);

    // Printable edges pass through; 0x55 gives an alternating line
    load(8'h55, 8'h7E, 8'h20, 8'h21);
    pulse_start(c0);
    expect_frames(c0, 64'h557E0D0A20210D0A, 8);
    dq.push_back(c0 + 3 + 8 * FRAME);
    wait_dump(c0, 1'b0);

    // dump_start while busy and on the FIN cycle is ignored
    load(8'h41, 8'h42, 8'h43, 8'h44);
    pulse_start(c0);
    expect_frames(c0, 64'h41420D0A43440D0A, 8);
    dq.push_back(c0 + 3 + 8 * FRAME);
    wait_dump(c0, 1'b1);

    // Reset inside the data bits of the third frame aborts the dump
    pulse_start(c0);
    expect_frames(c0, 64'h41420D0A43440D0A, 2);
    while (cyc < c0 + 3 + 2 * FRAME + 10) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_x", rd_x, 0);
    chk("abort_rd_y", rd_y, 0);
    repeat (60) @(negedge clk);
    chk("abort_frames_left", fq.size(), 0);
    chk("abort_busy_later", busy, 0);

    // Restart after the abort begins again at cell (0,0)
    load(8'h57, 8'h58, 8'h59, 8'h5A);
    pulse_start(c0);
    expect_frames(c0, 64'h57580D0A595A0D0A, 8);
    dq.push_back(c0 + 3 + 8 * FRAME);
    wait_dump(c0, 1'b0);

    // Reset wins over a simultaneous dump_start
    @(posedge clk); #1;
    reset      = 1'b1;
    dump_start = 1'b1;
    @(posedge clk); #1;
    reset      = 1'b0;
    dump_start = 1'b0;
    @(negedge clk);
    chk("prio_busy", busy, 0);
    chk("prio_tx", tx, 1);
    repeat (60) @(negedge clk);
    chk("prio_busy_later", busy, 0);
    chk("done_left", dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
